// File: rtl/data_mem_responder_pkg.sv
// ============================================================================
// Module      : data_mem_responder_pkg
// Description : Shared types and constants for the data memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package data_mem_responder_pkg;

    // Responder FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int LATENCY_DEFAULT     = 2;
    localparam int DEPTH_WORDS_DEFAULT = 1024;
    localparam int CNT_W               = 4;

endpackage

`default_nettype wire

// File: rtl/data_mem_array.sv
// ============================================================================
// Module      : data_mem_array
// Description : Single-port synchronous word RAM, word write-enable and
//               registered read data that holds until the next read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_d;
    logic [31:0] rdata_q;

    // Storage array; contents are deliberately not cleared by reset
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem_q[addr] <= wdata;
        end
    end

    // Read data only updates on an enabled read, otherwise holds
    always_comb begin
        rdata_d = rdata_q;
        if (en && !we) begin
            rdata_d = mem_q[addr];
        end
    end

    // Read data register, cleared by reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= 32'h0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
// Module      : data_mem_responder
// Description : MEM-stage data memory responder. Stalls the pipeline for
//               LATENCY cycles per aligned access, flags misaligned accesses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int LATENCY     = LATENCY_DEFAULT,
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        ErrM
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               store_q, store_d;
    logic               err_q, err_d;

    logic               w_req;
    logic               w_aligned;
    logic [AW-1:0]      w_idx;
    logic               w_unused_addr_bits;

    logic               w_acc_en;
    logic               w_acc_we;
    logic [AW-1:0]      w_acc_addr;
    logic [31:0]        w_acc_wdata;

    assign w_req              = MemReadM | MemWriteM;
    assign w_aligned          = (ALUResultM[1:0] == 2'b00);
    assign w_idx              = ALUResultM[AW+1:2];
    // Upper address bits are ignored so accesses wrap modulo the memory size
    assign w_unused_addr_bits = ^ALUResultM[31:AW+2];

    // Next-state, stall, error and memory-access decode
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        store_d     = store_q;
        err_d       = 1'b0;
        StallM      = 1'b0;
        w_acc_en    = 1'b0;
        w_acc_we    = store_q;
        w_acc_addr  = addr_q;
        w_acc_wdata = wdata_q;

        case (state_q)
            IDLE: begin
                if (w_req) begin
                    if (w_aligned) begin
                        StallM  = 1'b1;
                        addr_d  = w_idx;
                        wdata_d = WriteDataM;
                        store_d = MemWriteM;
                        if (LATENCY == 1) begin
                            // Single-cycle access completes on this edge,
                            // so the RAM sees the live inputs directly.
                            state_d     = DONE;
                            w_acc_en    = 1'b1;
                            w_acc_we    = MemWriteM;
                            w_acc_addr  = w_idx;
                            w_acc_wdata = WriteDataM;
                        end else begin
                            state_d = WAIT;
                            cnt_d   = CNT_W'(LATENCY - 2);
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                StallM = 1'b1;
                if (cnt_q == '0) begin
                    state_d  = DONE;
                    w_acc_en = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                // Inputs still belong to the completed instruction
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Reset aborts any access and drops the stall immediately
        if (!rst) begin
            StallM   = 1'b0;
            w_acc_en = 1'b0;
        end
    end

    // State, counter, latched request and error pulse registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            store_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            store_q <= store_d;
            err_q   <= err_d;
        end
    end

    assign ErrM = err_q;

    data_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .en    (w_acc_en),
        .we    (w_acc_we),
        .addr  (w_acc_addr),
        .wdata (w_acc_wdata),
        .rdata (ReadDataM)
    );

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Directed self-checking bench for data_mem_responder with
//               LATENCY=2 (instance a) and LATENCY=1 (instance b).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_responder;

    logic        clk = 1'b0;
    int          total = 0;
    int          bad   = 0;

    // Instance a: LATENCY = 2
    logic        a_rst, a_rd, a_wr;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        a_stall, a_err;

    // Instance b: LATENCY = 1
    logic        b_rst, b_rd, b_wr;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic        b_stall, b_err;

    always #5 clk = ~clk;

    data_mem_responder #(.LATENCY(2), .DEPTH_WORDS(1024)) dut_a (
        .clk        (clk),
        .rst        (a_rst),
        .MemReadM   (a_rd),
        .MemWriteM  (a_wr),
        .ALUResultM (a_addr),
        .WriteDataM (a_wdata),
        .ReadDataM  (a_rdata),
        .StallM     (a_stall),
        .ErrM       (a_err)
    );

    data_mem_responder #(.LATENCY(1), .DEPTH_WORDS(1024)) dut_b (
        .clk        (clk),
        .rst        (b_rst),
        .MemReadM   (b_rd),
        .MemWriteM  (b_wr),
        .ALUResultM (b_addr),
        .WriteDataM (b_wdata),
        .ReadDataM  (b_rdata),
        .StallM     (b_stall),
        .ErrM       (b_err)
    );

    // Drive one request on instance a, count stall cycles; returns in the
    // first non-stalled cycle (DONE for aligned, IDLE for misaligned).
    task automatic a_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] data, output int nstall);
        @(negedge clk);
        a_rd = rd; a_wr = wr; a_addr = addr; a_wdata = data;
        #1;
        nstall = 0;
        while (a_stall && nstall < 40) begin
            nstall++;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic a_idle();
        @(negedge clk);
        a_rd = 1'b0; a_wr = 1'b0; a_addr = 32'h0; a_wdata = 32'h0;
    endtask

    task automatic test_reset();
        a_rst = 1'b0; a_rd = 1'b1; a_wr = 1'b0; a_addr = 32'h0; a_wdata = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (a_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", a_stall); end
        total++;
        if (a_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=00000000", a_rdata); end
        total++;
        if (a_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", a_err); end
        a_idle();
        a_rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_store_load();
        int n;
        a_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, n);
        total++;
        if (n != 2) begin bad++; $display("FAIL store_stall_cycles got=%0d exp=2", n); end
        total++;
        if (a_rdata !== 32'h0) begin bad++; $display("FAIL store_rdata_held got=%h exp=00000000", a_rdata); end
        a_idle();
        a_access(1'b1, 1'b0, 32'h10, 32'h0, n);
        total++;
        if (n != 2) begin bad++; $display("FAIL load_stall_cycles got=%0d exp=2", n); end
        total++;
        if (a_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL load_rdata got=%h exp=deadbeef", a_rdata); end
        a_idle();
    endtask

    task automatic test_misaligned();
        int n;
        a_access(1'b0, 1'b1, 32'h4, 32'h01234567, n);
        a_idle();
        a_access(1'b1, 1'b0, 32'h6, 32'h0, n);
        total++;
        if (n != 0) begin bad++; $display("FAIL misaligned_stall got=%0d exp=0", n); end
        total++;
        if (a_err !== 1'b0) begin bad++; $display("FAIL misaligned_err_early got=%b exp=0", a_err); end
        a_idle();
        #1;
        total++;
        if (a_err !== 1'b1) begin bad++; $display("FAIL misaligned_err_pulse got=%b exp=1", a_err); end
        total++;
        if (a_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL misaligned_rdata got=%h exp=deadbeef", a_rdata); end
        @(negedge clk);
        #1;
        total++;
        if (a_err !== 1'b0) begin bad++; $display("FAIL misaligned_err_clear got=%b exp=0", a_err); end
        // Misaligned store must not touch word 1
        a_access(1'b0, 1'b1, 32'h5, 32'hFFFFFFFF, n);
        a_idle();
        a_access(1'b1, 1'b0, 32'h4, 32'h0, n);
        total++;
        if (a_rdata !== 32'h01234567) begin bad++; $display("FAIL misaligned_mem_intact got=%h exp=01234567", a_rdata); end
        a_idle();
    endtask

    task automatic test_inputs_in_wait();
        int n;
        a_access(1'b0, 1'b1, 32'h34, 32'h00000055, n);
        a_idle();
        @(negedge clk);
        a_rd = 1'b0; a_wr = 1'b1; a_addr = 32'h30; a_wdata = 32'hCAFEBABE;
        @(negedge clk);
        a_rd = 1'b1; a_addr = 32'h34; a_wdata = 32'h0;
        #1;
        total++;
        if (a_stall !== 1'b1) begin bad++; $display("FAIL wait_stall got=%b exp=1", a_stall); end
        @(negedge clk);
        #1;
        total++;
        if (a_stall !== 1'b0) begin bad++; $display("FAIL wait_done_stall got=%b exp=0", a_stall); end
        a_idle();
        a_access(1'b1, 1'b0, 32'h30, 32'h0, n);
        total++;
        if (a_rdata !== 32'hCAFEBABE) begin bad++; $display("FAIL wait_latched got=%h exp=cafebabe", a_rdata); end
        a_idle();
        a_access(1'b1, 1'b0, 32'h34, 32'h0, n);
        total++;
        if (a_rdata !== 32'h00000055) begin bad++; $display("FAIL wait_other_word got=%h exp=00000055", a_rdata); end
        a_idle();
    endtask

    task automatic test_wrap();
        int n;
        a_access(1'b0, 1'b1, 32'h1000, 32'h1, n);
        a_idle();
        a_access(1'b1, 1'b0, 32'h0, 32'h0, n);
        total++;
        if (a_rdata !== 32'h1) begin bad++; $display("FAIL wrap_rdata got=%h exp=00000001", a_rdata); end
        a_idle();
    endtask

    task automatic test_reset_abort();
        int n;
        a_access(1'b0, 1'b1, 32'h20, 32'hAAAA5555, n);
        a_idle();
        @(negedge clk);
        a_wr = 1'b1; a_addr = 32'h20; a_wdata = 32'h11111111;
        @(negedge clk);
        #1;
        total++;
        if (a_stall !== 1'b1) begin bad++; $display("FAIL abort_wait_stall got=%b exp=1", a_stall); end
        a_rst = 1'b0;
        #1;
        total++;
        if (a_stall !== 1'b0) begin bad++; $display("FAIL abort_stall_in_reset got=%b exp=0", a_stall); end
        @(negedge clk);
        a_rst = 1'b1; a_wr = 1'b0; a_addr = 32'h0; a_wdata = 32'h0;
        #1;
        total++;
        if (a_stall !== 1'b0 || a_rdata !== 32'h0) begin
            bad++; $display("FAIL abort_idle got stall=%b rdata=%h exp stall=0 rdata=00000000", a_stall, a_rdata);
        end
        a_access(1'b1, 1'b0, 32'h20, 32'h0, n);
        total++;
        if (n != 2) begin bad++; $display("FAIL abort_load_stall got=%0d exp=2", n); end
        total++;
        if (a_rdata !== 32'hAAAA5555) begin bad++; $display("FAIL abort_mem_kept got=%h exp=aaaa5555", a_rdata); end
        a_idle();
    endtask

    task automatic test_both_req();
        int n;
        a_access(1'b1, 1'b1, 32'h8, 32'h12345678, n);
        total++;
        if (n != 2) begin bad++; $display("FAIL both_stall got=%0d exp=2", n); end
        total++;
        if (a_rdata !== 32'hAAAA5555) begin bad++; $display("FAIL both_rdata_held got=%h exp=aaaa5555", a_rdata); end
        a_idle();
        a_access(1'b1, 1'b0, 32'h8, 32'h0, n);
        total++;
        if (a_rdata !== 32'h12345678) begin bad++; $display("FAIL both_stored got=%h exp=12345678", a_rdata); end
        a_idle();
    endtask

    task automatic test_latency1();
        b_rst = 1'b0;
        repeat (2) @(negedge clk);
        b_rst = 1'b1;
        @(negedge clk);
        b_wr = 1'b1; b_addr = 32'h4; b_wdata = 32'h5A5A0001;
        #1;
        total++;
        if (b_stall !== 1'b1) begin bad++; $display("FAIL l1_store_stall got=%b exp=1", b_stall); end
        @(negedge clk);
        #1;
        total++;
        if (b_stall !== 1'b0 || b_rdata !== 32'h0) begin
            bad++; $display("FAIL l1_store_done got stall=%b rdata=%h exp stall=0 rdata=00000000", b_stall, b_rdata);
        end
        @(negedge clk);
        b_wr = 1'b0; b_rd = 1'b1; b_wdata = 32'h0;
        #1;
        total++;
        if (b_stall !== 1'b1) begin bad++; $display("FAIL l1_load_stall got=%b exp=1", b_stall); end
        @(negedge clk);
        #1;
        total++;
        if (b_stall !== 1'b0 || b_rdata !== 32'h5A5A0001) begin
            bad++; $display("FAIL l1_load_done got stall=%b rdata=%h exp stall=0 rdata=5a5a0001", b_stall, b_rdata);
        end
        @(negedge clk);
        b_rd = 1'b0; b_addr = 32'h0;
        #1;
        total++;
        if (b_stall !== 1'b0) begin bad++; $display("FAIL l1_idle_stall got=%b exp=0", b_stall); end
    endtask

    initial begin
        b_rst = 1'b0; b_rd = 1'b0; b_wr = 1'b0; b_addr = 32'h0; b_wdata = 32'h0;
        test_reset();
        test_store_load();
        test_misaligned();
        test_inputs_in_wait();
        test_wrap();
        test_reset_abort();
        test_both_req();
        test_latency1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
